// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage: FSM states, FIFO entry layout, reset address.
package fetch_pkg;

    localparam int FETCH_ADDR_W = 32;
    localparam int FETCH_DATA_W = 32;
    localparam logic [FETCH_ADDR_W-1:0] FETCH_RESET_ADDR = '0;

    typedef enum logic [1:0] {
        FETCH_IDLE,
        FETCH_REQ,
        FETCH_DRAIN
    } fetch_state_t;

    typedef struct packed {
        logic [FETCH_DATA_W-1:0] instr;
        logic [FETCH_ADDR_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {instr, pc} entries; clear beats push and pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  fetch_entry_t     push_entry,
    input  logic             pop,
    input  logic             clear,
    output logic [CNT_W-1:0] count,
    output fetch_entry_t     head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues word reads at the PC, buffers returned instructions for decode.
// Optional FETCH_ALIGN_CHECK_EN adds a sticky misaligned-PC fault that blocks issue.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W = FETCH_ADDR_W,
    parameter int DATA_W = FETCH_DATA_W,
    parameter int DEPTH  = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_addr,
    output logic              pc_advance,
    input  logic              flush,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              ir_valid,
    output logic [DATA_W-1:0] ir_data,
    output logic [ADDR_W-1:0] ir_pc,
    input  logic              ir_ready,
    output logic              fetch_fault
);

    // state       | meaning
    // FETCH_IDLE  | no request outstanding; issue when FIFO has room
    // FETCH_REQ   | request outstanding, response will be kept
    // FETCH_DRAIN | request outstanding after flush, response discarded

    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_state_t     state, state_next;
    logic             issue;
    logic             push;
    logic             pop;
    logic             fault_block;
    logic [CNT_W-1:0] count;
    fetch_entry_t     push_entry;
    fetch_entry_t     head;

`ifdef FETCH_ALIGN_CHECK_EN
    logic fault_q;
    logic misaligned;

    assign misaligned = (state == FETCH_IDLE) && (pc_addr[1:0] != 2'b00);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fault_q <= 1'b0;
        end else if (misaligned) begin
            fault_q <= 1'b1;
        end
    end

    assign fault_block = fault_q || misaligned;
    assign fetch_fault = fault_q;
`else
    assign fault_block = 1'b0;
    assign fetch_fault = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= FETCH_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        push       = 1'b0;
        case (state)
            FETCH_IDLE: begin
                if ((count < CNT_W'(DEPTH)) && !flush && !fault_block) begin
                    issue      = 1'b1;
                    state_next = FETCH_REQ;
                end
            end
            FETCH_REQ: begin
                if (mem_ack) begin
                    push       = !flush;
                    state_next = FETCH_IDLE;
                end else if (flush) begin
                    state_next = FETCH_DRAIN;
                end
            end
            FETCH_DRAIN: begin
                if (mem_ack) begin
                    state_next = FETCH_IDLE;
                end
            end
            default: state_next = FETCH_IDLE;
        endcase
    end

    // Address only loads on issue, so it is stable for the whole request.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_addr <= FETCH_RESET_ADDR;
        end else if (issue) begin
            mem_addr <= pc_addr;
        end
    end

    assign mem_req    = (state != FETCH_IDLE);
    assign pc_advance = (state == FETCH_REQ) && mem_ack && !flush;

    assign push_entry.instr = mem_rdata;
    assign push_entry.pc    = mem_addr;
    assign pop              = ir_valid && ir_ready;

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .clear      (flush),
        .count      (count),
        .head       (head)
    );

    assign ir_valid = (count != '0);
    assign ir_data  = head.instr;
    assign ir_pc    = head.pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: zero-wait streaming, backpressure, wait states,
// flush with in-flight response, flush vs push/pop, and the misaligned-PC path.
module tb_instr_fetch_unit;

    logic        clock;
    logic        reset;
    logic [31:0] pc_addr;
    logic        pc_advance;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        ir_valid;
    logic [31:0] ir_data;
    logic [31:0] ir_pc;
    logic        ir_ready;
    logic        fetch_fault;

    int          checks;
    int          failures;
    int          adv_cnt;
    int          wait_cnt;
    int          latency;
    logic [31:0] flush_tgt;

    instr_fetch_unit dut (
        .clock       (clock),
        .reset       (reset),
        .pc_addr     (pc_addr),
        .pc_advance  (pc_advance),
        .flush       (flush),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .ir_valid    (ir_valid),
        .ir_data     (ir_data),
        .ir_pc       (ir_pc),
        .ir_ready    (ir_ready),
        .fetch_fault (fetch_fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: external PC register and a fixed-latency memory responder
    // are updated at the falling edge, away from the DUT's sampling edge.
    task automatic step();
        logic adv, rq, ak;
        adv = pc_advance;
        rq  = mem_req;
        ak  = mem_ack;
        if (adv) adv_cnt++;
        @(posedge clock);
        @(negedge clock);
        if (flush) pc_addr = flush_tgt;
        else if (adv) pc_addr = pc_addr + 32'd4;
        if (!rq || ak) wait_cnt = 0;
        else wait_cnt++;
        mem_ack   = mem_req && (wait_cnt >= latency);
        mem_rdata = mem_ack ? data_of(mem_addr) : 32'h0;
        #1;
    endtask

    task automatic do_reset(input logic [31:0] pc0, input logic rdy);
        @(negedge clock);
        reset     = 1'b1;
        flush     = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        ir_ready  = rdy;
        pc_addr   = pc0;
        wait_cnt  = 0;
        adv_cnt   = 0;
        #1;
        chk1 ("rst_mem_req", mem_req, 1'b0);
        chk32("rst_mem_addr", mem_addr, 32'h0);
        chk1 ("rst_pc_advance", pc_advance, 1'b0);
        chk1 ("rst_ir_valid", ir_valid, 1'b0);
        chk32("rst_ir_data", ir_data, 32'h0);
        chk32("rst_ir_pc", ir_pc, 32'h0);
        chk1 ("rst_fetch_fault", fetch_fault, 1'b0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        latency   = 0;
        flush_tgt = 32'h0;
        reset     = 1'b1;
        flush     = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        ir_ready  = 1'b1;
        pc_addr   = 32'h0;
        wait_cnt  = 0;
        adv_cnt   = 0;

        // Zero-wait streaming, decode always ready.
        latency = 0;
        do_reset(32'h0, 1'b1);
        chk1 ("s1_t0_req", mem_req, 1'b0);
        step();
        chk1 ("s1_t1_req", mem_req, 1'b1);
        chk32("s1_t1_addr", mem_addr, 32'h0);
        chk1 ("s1_t1_adv", pc_advance, 1'b1);
        step();
        chk1 ("s1_t2_req", mem_req, 1'b0);
        chk1 ("s1_t2_valid", ir_valid, 1'b1);
        chk32("s1_t2_pc", ir_pc, 32'h0);
        chk32("s1_t2_data", ir_data, data_of(32'h0));
        step();
        chk32("s1_t3_addr", mem_addr, 32'h4);
        chk1 ("s1_t3_valid", ir_valid, 1'b0);
        step();
        chk32("s1_t4_pc", ir_pc, 32'h4);
        step();
        chk32("s1_t5_addr", mem_addr, 32'h8);
        step();
        chk32("s1_t6_pc", ir_pc, 32'h8);
        chk32("s1_adv_cnt", 32'(adv_cnt), 32'd3);

        // Backpressure: FIFO fills after two fetches, then resumes after a pop.
        do_reset(32'h0, 1'b0);
        step(); step(); step(); step();
        chk1 ("s2_t4_req", mem_req, 1'b0);
        step();
        chk1 ("s2_t5_req", mem_req, 1'b0);
        step();
        chk1 ("s2_t6_req", mem_req, 1'b0);
        chk32("s2_t6_pc", ir_pc, 32'h0);
        ir_ready = 1'b1;
        step();
        chk1 ("s2_t7_req", mem_req, 1'b0);
        chk32("s2_t7_pc", ir_pc, 32'h4);
        step();
        chk1 ("s2_t8_req", mem_req, 1'b1);
        chk32("s2_t8_addr", mem_addr, 32'h8);
        chk1 ("s2_t8_valid", ir_valid, 1'b0);

        // Two wait states: request at 0x10 held three cycles.
        latency = 2;
        do_reset(32'h10, 1'b1);
        step();
        chk1 ("s3_t1_req", mem_req, 1'b1);
        chk32("s3_t1_addr", mem_addr, 32'h10);
        chk1 ("s3_t1_adv", pc_advance, 1'b0);
        step();
        chk32("s3_t2_addr", mem_addr, 32'h10);
        chk1 ("s3_t2_adv", pc_advance, 1'b0);
        step();
        chk1 ("s3_t3_req", mem_req, 1'b1);
        chk32("s3_t3_addr", mem_addr, 32'h10);
        chk1 ("s3_t3_adv", pc_advance, 1'b1);
        step();
        chk1 ("s3_t4_req", mem_req, 1'b0);
        chk32("s3_t4_pc", ir_pc, 32'h10);
        chk32("s3_adv_cnt", 32'(adv_cnt), 32'd1);

        // Flush while waiting on 0x20; late response discarded, refetch at 0x100.
        latency = 2;
        do_reset(32'h20, 1'b1);
        step();
        chk32("s4_t1_addr", mem_addr, 32'h20);
        flush     = 1'b1;
        flush_tgt = 32'h100;
        #1;
        chk1 ("s4_t1_adv", pc_advance, 1'b0);
        step();
        flush = 1'b0;
        #1;
        chk1 ("s4_t2_req", mem_req, 1'b1);
        chk32("s4_t2_addr", mem_addr, 32'h20);
        step();
        chk1 ("s4_t3_ack", mem_ack, 1'b1);
        chk1 ("s4_t3_adv", pc_advance, 1'b0);
        step();
        chk1 ("s4_t4_req", mem_req, 1'b0);
        chk1 ("s4_t4_valid", ir_valid, 1'b0);
        chk32("s4_adv_cnt", 32'(adv_cnt), 32'd0);
        latency = 0;
        step();
        chk1 ("s4_t5_req", mem_req, 1'b1);
        chk32("s4_t5_addr", mem_addr, 32'h100);
        step();
        chk32("s4_t6_pc", ir_pc, 32'h100);

        // Flush on the same edge as a push and a pop.
        latency = 0;
        do_reset(32'h0, 1'b0);
        step(); step(); step();
        chk1 ("s5_t3_valid", ir_valid, 1'b1);
        chk1 ("s5_t3_ack", mem_ack, 1'b1);
        ir_ready  = 1'b1;
        flush     = 1'b1;
        flush_tgt = 32'h40;
        #1;
        chk1 ("s5_t3_adv", pc_advance, 1'b0);
        step();
        flush = 1'b0;
        #1;
        chk1 ("s5_t4_valid", ir_valid, 1'b0);
        chk1 ("s5_t4_req", mem_req, 1'b0);
        step();
        chk1 ("s5_t5_req", mem_req, 1'b1);
        chk32("s5_t5_addr", mem_addr, 32'h40);

`ifdef FETCH_ALIGN_CHECK_EN
        // Misaligned PC: sticky fault, no issue, buffered entry still drains.
        latency = 0;
        do_reset(32'h0, 1'b0);
        step(); step();
        chk1("s6_t2_valid", ir_valid, 1'b1);
        pc_addr = 32'h6;
        step();
        chk1 ("s6_t3_fault", fetch_fault, 1'b1);
        chk1 ("s6_t3_req", mem_req, 1'b0);
        chk32("s6_t3_pc", ir_pc, 32'h0);
        ir_ready = 1'b1;
        pc_addr  = 32'h8;
        step();
        chk1("s6_t4_valid", ir_valid, 1'b0);
        step();
        chk1("s6_t5_fault", fetch_fault, 1'b1);
        chk1("s6_t5_req", mem_req, 1'b0);
        do_reset(32'h8, 1'b1);
        chk1("s6_clr_fault", fetch_fault, 1'b0);
        step();
        chk1 ("s6_req_after_rst", mem_req, 1'b1);
        chk32("s6_addr_after_rst", mem_addr, 32'h8);
`else
        // Without the check, low PC bits pass straight through.
        latency = 0;
        do_reset(32'h6, 1'b1);
        step();
        chk1 ("s6_req", mem_req, 1'b1);
        chk32("s6_addr", mem_addr, 32'h6);
        chk1 ("s6_fault", fetch_fault, 1'b0);
`endif

        // Asynchronous reset in the middle of a request.
        latency = 3;
        do_reset(32'h30, 1'b1);
        step();
        chk1("s7_req_before", mem_req, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk1 ("s7_req_async", mem_req, 1'b0);
        chk32("s7_addr_async", mem_addr, 32'h0);
        @(negedge clock);
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
